decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREGS, default 32, register count; legal values 16 (RV32E) or 32.
REQ-003 Parameter ADDR_W, default 32, width of mem_addr_o; low ADDR_W bits of effective address.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 in_valid_i  in  1  instruction_i valid.
REQ-007 in_ready_o  out  1  stage accepts instruction this cycle.
REQ-008 instruction_i  in  32  RV32I instruction word.
REQ-009 wb_en_i  in  1  register-file write enable.
REQ-010 wb_addr_i  in  5  write register index.
REQ-011 wb_data_i  in  XLEN  write data.
REQ-012 out_valid_o  out  1  decoded bundle valid.
REQ-013 out_ready_i  in  1  downstream accepts bundle.
REQ-014 aluControl_o  out  4  ALU op: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10.
REQ-015 op1_o, op2_o  out  XLEN each  ALU operands.
REQ-016 rd_o  out  5  destination index; rd_we_o  out  1  destination write enable.
REQ-017 mem_en_o, mem_wr_o  out  1 each  memory access, store flag.
REQ-018 mem_addr_o  out  ADDR_W  rs1+imm; store_data_o  out  XLEN  rs2 value.
REQ-019 illegal_o  out  1  unsupported or out-of-range instruction.

Function
REQ-020 Register file NREGS x XLEN; x0 reads 0 always; writes to x0 discarded.
REQ-021 Write when wb_en_i=1 and wb_addr_i<NREGS, at clock edge; wb_addr_i>=NREGS ignored.
REQ-022 Same-cycle bypass: wb_en_i=1, wb_addr_i==rs (nonzero) -> read returns wb_data_i.
REQ-023 Handshake: in_ready_o = !out_valid_o || out_ready_i; accept on in_valid_i && in_ready_o.
REQ-024 Accepted instruction -> output register next edge; latency 1 cycle; out_valid_o=1.
REQ-025 out_valid_o && !out_ready_i -> all outputs held stable; no new accept.
REQ-026 out_ready_i=1 with no accept -> out_valid_o cleared next edge; fields hold last values.
REQ-027 Back-to-back accept/consume sustains 1 instruction per cycle.
REQ-028 OP (0110011): funct3/funct7[5] -> ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; op1=rs1, op2=rs2, rd_we=1.
REQ-029 OP-IMM (0010011): same ops, op2=sign-extended imm[11:0]; SRLI/SRAI by imm[10]; shamt=imm[4:0].
REQ-030 LUI (0110111): PASSB, op2={imm[31:12],12'b0}, op1=0, rd_we=1.
REQ-031 LOAD (0000011): ADD, mem_en=1, mem_wr=0, rd_we=1, mem_addr=rs1+sext(I-imm).
REQ-032 STORE (0100011): ADD, mem_en=1, mem_wr=1, rd_we=0, mem_addr=rs1+sext(S-imm), store_data=rs2.
REQ-033 Address arithmetic modulo 2^XLEN, truncated to ADDR_W.
REQ-034 Any other opcode, invalid funct7 on OP, or rs1/rs2/rd >= NREGS -> illegal_o=1, rd_we=0, mem_en=0, mem_wr=0, aluControl=ADD.
REQ-035 Non-illegal bundle -> illegal_o=0; non-memory ops -> mem_en=0, mem_wr=0.

Reset
REQ-036 reset_i=1 at edge: out_valid_o=0, all output fields 0, all registers 0.
REQ-037 in_ready_o=1 during and after reset; instruction presented during reset not accepted.
REQ-038 Reset mid-stall discards held bundle; reset overrides simultaneous write-back.

Verification
REQ-039 Reset, write x11=5, accept 0x02258513 (addi a0,a1,34) -> next cycle out_valid=1, op1=5, op2=34, aluControl=0, rd=10, rd_we=1.
REQ-040 x11=9, x12=4, accept 0x40c58533 (sub a0,a1,a2) -> op1=9, op2=4, aluControl=1.
REQ-041 Same cycle wb x11=0x77 and addi a0,a1,34 accepted -> op1=0x77.
REQ-042 out_ready_i=0 for 3 cycles with valid bundle -> outputs stable, in_ready_o=0; release -> next instruction accepted same cycle.
REQ-043 NREGS=16, add x20,x1,x2 -> illegal_o=1, rd_we=0; opcode 0x7F -> illegal_o=1.
REQ-044 x2=0x100, sw x5,-4(x2) -> mem_en=1, mem_wr=1, mem_addr=0xFC, store_data=x5; reset during stall -> out_valid=0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/E decode stage: register file with write-back bypass, instruction decode
// and a single output register behind a valid/ready handshake.
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instruction_i,
    input  logic              wb_en_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        aluControl_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [4:0]        rd_o,
    output logic              rd_we_o,
    output logic              mem_en_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic              illegal_o
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam int         RIDX_W  = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREGS_L;
    endfunction

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
    logic            accept;

    assign opcode = instruction_i[6:0];
    assign rd     = instruction_i[11:7];
    assign funct3 = instruction_i[14:12];
    assign rs1    = instruction_i[19:15];
    assign rs2    = instruction_i[24:20];
    assign funct7 = instruction_i[31:25];

    assign imm_i = XLEN'($signed(instruction_i[31:20]));
    assign imm_s = XLEN'($signed({instruction_i[31:25], instruction_i[11:7]}));
    assign imm_u = XLEN'($signed({instruction_i[31:12], 12'b0}));
    assign shamt = XLEN'(instruction_i[24:20]);

    // Reset is forced ready so nothing stalls upstream while the stage clears.
    assign in_ready_o = reset_i || !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !reset_i;

    // NOTE: every variable gets a default at the top of an always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rs1_val = '0;
        if (rs1 != 5'd0 && in_range(rs1)) begin
            if (wb_en_i && wb_addr_i == rs1) rs1_val = wb_data_i;
            else                             rs1_val = regs[rs1[RIDX_W-1:0]];
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0 && in_range(rs2)) begin
            if (wb_en_i && wb_addr_i == rs2) rs2_val = wb_data_i;
            else                             rs2_val = regs[rs2[RIDX_W-1:0]];
        end
    end

    alu_op_e         d_alu;
    logic [XLEN-1:0] d_op1, d_op2, d_addr_imm, d_ea;
    logic            d_rd_we, d_mem_en, d_mem_wr, d_illegal;

    always_comb begin
        d_alu      = ALU_ADD;
        d_op1      = rs1_val;
        d_op2      = rs2_val;
        d_addr_imm = imm_i;
        d_rd_we    = 1'b0;
        d_mem_en   = 1'b0;
        d_mem_wr   = 1'b0;
        d_illegal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_rd_we = 1'b1;
                if (!in_range(rs1) || !in_range(rs2) || !in_range(rd)) d_illegal = 1'b1;
                // Only SUB and SRA may carry the alternate funct7.
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    d_illegal = 1'b1;
                case (funct3)
                    3'b000: d_alu = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: d_alu = ALU_SLL;
                    3'b010: d_alu = ALU_SLT;
                    3'b011: d_alu = ALU_SLTU;
                    3'b100: d_alu = ALU_XOR;
                    3'b101: d_alu = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                d_rd_we = 1'b1;
                d_op2   = imm_i;
                if (!in_range(rs1) || !in_range(rd)) d_illegal = 1'b1;
                case (funct3)
                    3'b000: d_alu = ALU_ADD;
                    3'b001: begin d_alu = ALU_SLL; d_op2 = shamt; end
                    3'b010: d_alu = ALU_SLT;
                    3'b011: d_alu = ALU_SLTU;
                    3'b100: d_alu = ALU_XOR;
                    3'b101: begin
                        d_alu = instruction_i[30] ? ALU_SRA : ALU_SRL;
                        d_op2 = shamt;
                    end
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                d_alu   = ALU_PASSB;
                d_op1   = '0;
                d_op2   = imm_u;
                d_rd_we = 1'b1;
                if (!in_range(rd)) d_illegal = 1'b1;
            end
            OPC_LOAD: begin
                d_op2    = imm_i;
                d_rd_we  = 1'b1;
                d_mem_en = 1'b1;
                if (!in_range(rs1) || !in_range(rd)) d_illegal = 1'b1;
            end
            OPC_STORE: begin
                d_op2      = imm_s;
                d_addr_imm = imm_s;
                d_mem_en   = 1'b1;
                d_mem_wr   = 1'b1;
                if (!in_range(rs1) || !in_range(rs2)) d_illegal = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_alu    = ALU_ADD;
            d_rd_we  = 1'b0;
            d_mem_en = 1'b0;
            d_mem_wr = 1'b0;
        end
    end

    assign d_ea = rs1_val + d_addr_imm;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_o  <= 1'b0;
            aluControl_o <= ALU_ADD;
            op1_o        <= '0;
            op2_o        <= '0;
            rd_o         <= '0;
            rd_we_o      <= 1'b0;
            mem_en_o     <= 1'b0;
            mem_wr_o     <= 1'b0;
            mem_addr_o   <= '0;
            store_data_o <= '0;
            illegal_o    <= 1'b0;
        end else if (accept) begin
            out_valid_o  <= 1'b1;
            aluControl_o <= d_alu;
            op1_o        <= d_op1;
            op2_o        <= d_op2;
            rd_o         <= rd;
            rd_we_o      <= d_rd_we;
            mem_en_o     <= d_mem_en;
            mem_wr_o     <= d_mem_wr;
            mem_addr_o   <= ADDR_W'(d_ea);
            store_data_o <= rs2_val;
            illegal_o    <= d_illegal;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // NOTE: the register file is architecturally cleared by reset, so the array
    // is reset explicitly; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en_i && wb_addr_i != 5'd0 && in_range(wb_addr_i)) begin
            regs[wb_addr_i[RIDX_W-1:0]] <= wb_data_i;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (RV32E build): directed scenarios followed by
// randomized traffic checked against an instruction-level reference model.
module tb_decode_stage;

    localparam int XLEN   = 32;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       instruction_i;
    logic              wb_en_i;
    logic [4:0]        wb_addr_i;
    logic [XLEN-1:0]   wb_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [3:0]        aluControl_o;
    logic [XLEN-1:0]   op1_o, op2_o;
    logic [4:0]        rd_o;
    logic              rd_we_o, mem_en_o, mem_wr_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [XLEN-1:0]   store_data_o;
    logic              illegal_o;

    decode_stage #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .instruction_i(instruction_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .aluControl_o(aluControl_o), .op1_o(op1_o), .op2_o(op2_o),
        .rd_o(rd_o), .rd_we_o(rd_we_o), .mem_en_o(mem_en_o), .mem_wr_o(mem_wr_o),
        .mem_addr_o(mem_addr_o), .store_data_o(store_data_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  alu;
        logic [31:0] op1, op2, addr, sd;
        logic [4:0]  rd;
        logic        rd_we, mem_en, mem_wr, illegal;
        bit          k_ops, k_rd, k_addr, k_sd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    logic        m_valid = 1'b0;
    bit          mon_on = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rval(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 0 || idx >= NREGS) return 32'd0;
        if (we && wa == idx) return wd;
        return mregs[idx];
    endfunction

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'd0;   // ADD
            3'd1: return 4'd2;   // SLL
            3'd2: return 4'd3;   // SLT
            3'd3: return 4'd4;   // SLTU
            3'd4: return 4'd5;   // XOR
            3'd5: return 4'd6;   // SRL
            3'd6: return 4'd8;   // OR
            default: return 4'd9; // AND
        endcase
    endfunction

    function automatic exp_t predict(input logic [31:0] ins, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        int unsigned r1i = ins[19:15], r2i = ins[24:20], rdi = ins[11:7];
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [31:0] r1 = rval(ins[19:15], we, wa, wd);
        logic [31:0] r2 = rval(ins[24:20], we, wa, wd);
        logic signed [31:0] immi = $signed(ins[31:20]);
        logic signed [31:0] imms = $signed({ins[31:25], ins[11:7]});
        e.alu = 4'd0; e.op1 = 0; e.op2 = 0; e.addr = 0; e.sd = 0; e.rd = ins[11:7];
        e.rd_we = 0; e.mem_en = 0; e.mem_wr = 0; e.illegal = 0;
        e.k_ops = 0; e.k_rd = 0; e.k_addr = 0; e.k_sd = 0;
        case (ins[6:0])
            7'h33: begin
                e.alu = base_op(f3); e.op1 = r1; e.op2 = r2; e.rd_we = 1;
                e.k_ops = 1; e.k_rd = 1;
                if (f7 == 7'd32 && f3 == 3'd0)      e.alu = 4'd1;
                else if (f7 == 7'd32 && f3 == 3'd5) e.alu = 4'd7;
                else if (f7 != 7'd0)                e.illegal = 1;
                if (r1i >= NREGS || r2i >= NREGS || rdi >= NREGS) e.illegal = 1;
            end
            7'h13: begin
                e.alu = base_op(f3); e.op1 = r1; e.op2 = immi; e.rd_we = 1;
                e.k_ops = 1; e.k_rd = 1;
                if (f3 == 3'd1 || f3 == 3'd5) e.op2 = {27'd0, ins[24:20]};
                if (f3 == 3'd5 && ins[30]) e.alu = 4'd7;
                if (r1i >= NREGS || rdi >= NREGS) e.illegal = 1;
            end
            7'h37: begin
                e.alu = 4'd10; e.op1 = 0; e.op2 = {ins[31:12], 12'd0}; e.rd_we = 1;
                e.k_ops = 1; e.k_rd = 1;
                if (rdi >= NREGS) e.illegal = 1;
            end
            7'h03: begin
                e.mem_en = 1; e.rd_we = 1; e.addr = r1 + immi; e.k_addr = 1; e.k_rd = 1;
                if (r1i >= NREGS || rdi >= NREGS) e.illegal = 1;
            end
            7'h23: begin
                e.mem_en = 1; e.mem_wr = 1; e.addr = r1 + imms; e.sd = r2;
                e.k_addr = 1; e.k_sd = 1;
                if (r1i >= NREGS || r2i >= NREGS) e.illegal = 1;
            end
            default: e.illegal = 1;
        endcase
        if (e.illegal) begin
            e.alu = 0; e.rd_we = 0; e.mem_en = 0; e.mem_wr = 0;
            e.k_ops = 0; e.k_rd = 0; e.k_addr = 0; e.k_sd = 0;
        end
        return e;
    endfunction

    // One clock cycle: drive inputs, predict, advance the model at the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic ordy, input logic rst);
        logic acc;
        in_valid_i = v; instruction_i = ins; wb_en_i = we; wb_addr_i = wa;
        wb_data_i = wd; out_ready_i = ordy; reset_i = rst;
        acc = v && !rst && (!m_valid || ordy);
        if (acc) sb.push_back(predict(ins, we, wa, wd));
        @(posedge clk_i);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            sb.delete();
            m_valid = 1'b0;
        end else begin
            if (we && wa != 0 && wa < NREGS) mregs[wa] = wd;
            if (acc)       m_valid = 1'b1;
            else if (ordy) m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        wait (mon_on);
        forever begin
            @(negedge clk_i);
            check("out_valid", out_valid_o, m_valid);
            check("in_ready", in_ready_o, reset_i || !m_valid || out_ready_i);
            if (!reset_i && out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("alu", aluControl_o, e.alu);
                    check("illegal", illegal_o, e.illegal);
                    check("rd_we", rd_we_o, e.rd_we);
                    check("mem_en", mem_en_o, e.mem_en);
                    check("mem_wr", mem_wr_o, e.mem_wr);
                    if (e.k_ops)  begin check("op1", op1_o, e.op1); check("op2", op2_o, e.op2); end
                    if (e.k_rd)   check("rd", rd_o, e.rd);
                    if (e.k_addr) check("mem_addr", mem_addr_o, e.addr);
                    if (e.k_sd)   check("store_data", store_data_o, e.sd);
                end
            end
        end
    end

    localparam logic [31:0] ADDI_A0 = 32'h02258513; // addi a0,a1,34
    localparam logic [31:0] SUB_A0  = 32'h40c58533; // sub a0,a1,a2
    localparam logic [31:0] ADD_X20 = 32'h00208A33; // add x20,x1,x2
    localparam logic [31:0] SW_X5   = 32'hFE512E23; // sw x5,-4(x2)
    localparam logic [31:0] ADDI_X3 = 32'h00018313; // addi x6,x3,0

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins = $urandom;
        int unsigned pick = $urandom_range(0, 9);
        int unsigned f7sel = $urandom_range(0, 7);
        ins[11:7] = rnd_reg(); ins[19:15] = rnd_reg(); ins[24:20] = rnd_reg();
        if (pick <= 2) begin
            ins[6:0] = 7'h33;
            ins[31:25] = (f7sel <= 3) ? 7'd0 : (f7sel <= 6) ? 7'd32 : 7'($urandom);
        end
        else if (pick <= 4) ins[6:0] = 7'h13;
        else if (pick == 5) ins[6:0] = 7'h37;
        else if (pick <= 7) ins[6:0] = 7'h03;
        else if (pick == 8) ins[6:0] = 7'h23;
        return ins;
    endfunction

    initial begin : stimulus
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, ADDI_A0, 0, 0, 0, 0, 1);   // offered during reset, must be dropped
        check("rst_in_ready", in_ready_o, 1);
        check("rst_valid", out_valid_o, 0);
        check("rst_fields", {aluControl_o, rd_o, rd_we_o, mem_en_o, mem_wr_o, illegal_o}, 0);
        check("rst_data", {op1_o, op2_o}, 0);
        check("rst_mem", {mem_addr_o, store_data_o}, 0);
        mon_on = 1;

        step(0, 0, 1, 11, 5, 1, 0);
        step(1, ADDI_A0, 0, 0, 0, 1, 0);
        check("addi_valid", out_valid_o, 1);
        check("addi_op1", op1_o, 5);
        check("addi_op2", op2_o, 34);
        check("addi_alu", aluControl_o, 0);
        check("addi_rd", {rd_o, rd_we_o}, {5'd10, 1'b1});

        step(0, 0, 1, 11, 9, 1, 0);
        step(0, 0, 1, 12, 4, 1, 0);
        step(1, SUB_A0, 0, 0, 0, 1, 0);
        check("sub_ops", {op1_o, op2_o}, {32'd9, 32'd4});
        check("sub_alu", aluControl_o, 1);

        step(1, ADDI_A0, 1, 11, 32'h77, 1, 0);
        check("bypass_op1", op1_o, 32'h77);

        for (int i = 0; i < 3; i++) begin
            step(1, SUB_A0, 0, 0, 0, 0, 0);
            check("stall_valid", out_valid_o, 1);
            check("stall_ready", in_ready_o, 0);
            check("stall_hold", {op1_o, op2_o, aluControl_o, rd_o}, {32'h77, 32'd34, 4'd0, 5'd10});
        end
        step(1, SUB_A0, 0, 0, 0, 1, 0);
        check("release_take", {out_valid_o, op1_o, op2_o, aluControl_o}, {1'b1, 32'h77, 32'd4, 4'd1});

        step(1, ADD_X20, 0, 0, 0, 1, 0);
        check("x20_illegal", {illegal_o, rd_we_o}, 2'b10);
        step(1, 32'h0000007F, 0, 0, 0, 1, 0);
        check("opc7f_illegal", {illegal_o, rd_we_o, mem_en_o}, 3'b100);

        step(0, 0, 1, 2, 32'h100, 1, 0);
        step(0, 0, 1, 5, 32'hDEADBEEF, 1, 0);
        step(1, SW_X5, 0, 0, 0, 0, 0);
        check("sw_mem", {mem_en_o, mem_wr_o, rd_we_o, illegal_o}, 4'b1100);
        check("sw_addr", mem_addr_o, 32'hFC);
        check("sw_data", store_data_o, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, ADDI_A0, 1, 3, 32'h1234, 0, 1);  // reset beats stall and write-back
        check("stall_rst_valid", out_valid_o, 0);
        step(1, ADDI_X3, 0, 0, 0, 1, 0);
        check("x3_cleared", op1_o, 0);

        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 4) != 0), rnd_instr(), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15)),
                 $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 249) == 0));
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
